// File: rtl/conv_mac_pkg.sv
// Shared constants and helpers for the conv_mac_pipe datapath.
package conv_mac_pkg;

  // Overflow handling selections for SAT_MODE.
  localparam int SAT_WRAP  = 0;
  localparam int SAT_CLAMP = 1;

  // Legal multiplier pipeline depth.
  localparam int NUM_STAGE_MIN = 1;
  localparam int NUM_STAGE_MAX = 6;

  // Largest positive value of a w-bit signed result (truncate to w bits at use).
  function automatic logic [63:0] dout_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative value of a w-bit signed result (truncate to w bits at use).
  function automatic logic [63:0] dout_min(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/conv_mac_pipe_mul.sv
// ce-gated signed multiplier with a NUM_STAGE-deep output pipeline.
// The valid/first/last sideband travels alongside the product so the
// accumulator sees each beat's framing exactly when its product arrives.
// Registers sit behind the multiply with no reset on the datapath so that
// synthesis can retime them into the DSP block's internal pipeline.
module conv_mac_pipe_mul
  import conv_mac_pkg::*;
#(
  parameter int NUM_STAGE = 3,
  parameter int A_W       = 16,
  parameter int B_W       = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ce,
  input  logic                    in_valid,
  input  logic                    in_first,
  input  logic                    in_last,
  input  logic signed [A_W-1:0]   din0,
  input  logic signed [B_W-1:0]   din1,
  output logic                    out_valid,
  output logic                    out_first,
  output logic                    out_last,
  output logic signed [A_W+B_W-1:0] prod
);

  localparam int P_W   = A_W + B_W;
  localparam int DEPTH = (NUM_STAGE < NUM_STAGE_MIN) ? NUM_STAGE_MIN :
                         (NUM_STAGE > NUM_STAGE_MAX) ? NUM_STAGE_MAX : NUM_STAGE;

  logic signed [P_W-1:0] a_ext;
  logic signed [P_W-1:0] b_ext;
  logic signed [P_W-1:0] p_q [DEPTH];
  logic [DEPTH-1:0]      v_q;
  logic [DEPTH-1:0]      f_q;
  logic [DEPTH-1:0]      l_q;

  // Operands widened to the full product width so the multiply is exact.
  assign a_ext = P_W'(din0);
  assign b_ext = P_W'(din1);

  // Valid bits: the only pipeline state that reset must clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q <= '0;
    end else if (ce) begin
      v_q[0] <= in_valid;
      for (int i = 1; i < DEPTH; i++) v_q[i] <= v_q[i-1];
    end
  end

  // Product and framing flags; meaningful only where the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (ce) begin
      p_q[0] <= a_ext * b_ext;
      f_q[0] <= in_first;
      l_q[0] <= in_last;
      for (int i = 1; i < DEPTH; i++) begin
        p_q[i] <= p_q[i-1];
        f_q[i] <= f_q[i-1];
        l_q[i] <= l_q[i-1];
      end
    end
  end

  assign out_valid = v_q[DEPTH-1];
  assign out_first = f_q[DEPTH-1];
  assign out_last  = l_q[DEPTH-1];
  assign prod      = p_q[DEPTH-1];

endmodule

// File: rtl/conv_mac_pipe.sv
// Pipelined signed multiply-accumulate reducing one kernel window to one result.
// Handshake: a beat is taken on every rising edge with ce=1 and in_valid=1
// (there is no backpressure); in_first/in_last are qualified by in_valid.
// out_valid marks dout/overflow as a window result for exactly one enabled
// cycle; with ce=0 all outputs hold, so a consumer samples only when ce=1.
module conv_mac_pipe
  import conv_mac_pkg::*;
#(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 16,
  parameter int din1_WIDTH = 8,
  parameter int dout_WIDTH = 32,
  parameter int SAT_MODE   = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce,
  input  logic                         in_valid,
  input  logic                         in_first,
  input  logic                         in_last,
  input  logic signed [din0_WIDTH-1:0] din0,
  input  logic signed [din1_WIDTH-1:0] din1,
  output logic                         out_valid,
  output logic signed [dout_WIDTH-1:0] dout,
  output logic                         overflow
);

  localparam int P_W = din0_WIDTH + din1_WIDTH;
  localparam int MSB = dout_WIDTH - 1;
  localparam logic signed [dout_WIDTH-1:0] ACC_MAX = dout_WIDTH'(dout_max(dout_WIDTH));
  localparam logic signed [dout_WIDTH-1:0] ACC_MIN = dout_WIDTH'(dout_min(dout_WIDTH));

  logic                  m_valid;
  logic                  m_first;
  logic                  m_last;
  logic signed [P_W-1:0] m_prod;

  logic signed [dout_WIDTH-1:0] acc_q;
  logic                         win_ovf_q;
  logic signed [dout_WIDTH-1:0] base;
  logic signed [dout_WIDTH-1:0] addend;
  logic signed [dout_WIDTH-1:0] sum;
  logic signed [dout_WIDTH-1:0] acc_d;
  logic                         base_ovf;
  logic                         add_ovf;
  logic                         win_ovf_d;

  conv_mac_pipe_mul #(
    .NUM_STAGE (NUM_STAGE),
    .A_W       (din0_WIDTH),
    .B_W       (din1_WIDTH)
  ) u_mul (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .in_valid  (in_valid),
    .in_first  (in_first),
    .in_last   (in_last),
    .din0      (din0),
    .din1      (din1),
    .out_valid (m_valid),
    .out_first (m_first),
    .out_last  (m_last),
    .prod      (m_prod)
  );

  // Next accumulator value: a first beat restarts from zero with a clean
  // overflow bit; same-sign operands giving a different-sign sum overflowed.
  always_comb begin
    base      = m_first ? '0 : acc_q;
    base_ovf  = m_first ? 1'b0 : win_ovf_q;
    addend    = dout_WIDTH'(m_prod);
    sum       = base + addend;
    add_ovf   = (base[MSB] == addend[MSB]) && (sum[MSB] != base[MSB]);
    acc_d     = sum;
    if ((SAT_MODE == SAT_CLAMP) && add_ovf) acc_d = base[MSB] ? ACC_MIN : ACC_MAX;
    win_ovf_d = base_ovf | add_ovf;
  end

  // Running window sum and sticky overflow; bubbles leave them untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q     <= '0;
      win_ovf_q <= 1'b0;
    end else if (ce && m_valid) begin
      acc_q     <= acc_d;
      win_ovf_q <= win_ovf_d;
    end
  end

  // Result registers: publish on a last beat, otherwise drop out_valid and keep dout.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      dout      <= '0;
      overflow  <= 1'b0;
    end else if (ce) begin
      out_valid <= m_valid && m_last;
      if (m_valid && m_last) begin
        dout     <= acc_d;
        overflow <= win_ovf_d;
      end
    end
  end

endmodule

// File: tb/tb_conv_mac_pipe.sv
// Self-checking bench for conv_mac_pipe: a 24-bit wrapping instance (depth 3)
// and a 24-bit saturating instance (depth 2) share one stimulus stream and
// are checked against an integer-arithmetic window model.
module tb_conv_mac_pipe;

  localparam int NS_W = 3;
  localparam int NS_S = 2;
  localparam int DW   = 24;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ce = 1'b1;
  logic in_valid = 1'b0;
  logic in_first = 1'b0;
  logic in_last = 1'b0;
  logic signed [15:0] din0 = '0;
  logic signed [7:0]  din1 = '0;

  logic                 ov_w, ovf_w, ov_s, ovf_s;
  logic signed [DW-1:0] dout_w, dout_s;

  int n_tests = 0;
  int n_fail  = 0;
  int en_cnt  = 0;

  // Expected results: {overflow, 32-bit sign-extended dout}, plus expected enabled-edge count.
  logic [32:0] exp_w_q[$];
  logic [32:0] exp_s_q[$];
  int          lat_w_q[$];
  int          lat_s_q[$];

  longint acc_w = 0, acc_s = 0;
  bit     fl_w = 1'b0, fl_s = 1'b0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  conv_mac_pipe #(.ID(1), .NUM_STAGE(NS_W), .din0_WIDTH(16), .din1_WIDTH(8),
                  .dout_WIDTH(DW), .SAT_MODE(0)) u_wrap (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .din0(din0), .din1(din1),
    .out_valid(ov_w), .dout(dout_w), .overflow(ovf_w));

  conv_mac_pipe #(.ID(2), .NUM_STAGE(NS_S), .din0_WIDTH(16), .din1_WIDTH(8),
                  .dout_WIDTH(DW), .SAT_MODE(1)) u_sat (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .din0(din0), .din1(din1),
    .out_valid(ov_s), .dout(dout_s), .overflow(ovf_s));

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Exact integer sum, range-checked against the w-bit signed range.
  function automatic void model_add(input longint p, input int w, input bit sat,
                                    input bit first, inout longint acc, inout bit fl);
    longint mx, mn, s;
    mx = (longint'(1) <<< (w - 1)) - 1;
    mn = -mx - 1;
    if (first) begin
      acc = 0;
      fl  = 1'b0;
    end
    s = acc + p;
    if (s > mx || s < mn) begin
      fl = 1'b1;
      if (sat) s = (s > mx) ? mx : mn;
      else if (s > mx) s = s - (longint'(1) <<< w);
      else s = s + (longint'(1) <<< w);
    end
    acc = s;
  endfunction

  // Negedge: first score outputs of the last edge, then model the inputs of the next edge.
  always @(negedge clk) begin
    longint p;
    if (!reset && ce && ov_w) begin
      check("w_expected_pending", exp_w_q.size() != 0, 1);
      if (exp_w_q.size() != 0) begin
        check("w_result", {ovf_w, 32'(dout_w)}, exp_w_q.pop_front());
        check("w_latency", en_cnt, lat_w_q.pop_front());
      end
    end
    if (!reset && ce && ov_s) begin
      check("s_expected_pending", exp_s_q.size() != 0, 1);
      if (exp_s_q.size() != 0) begin
        check("s_result", {ovf_s, 32'(dout_s)}, exp_s_q.pop_front());
        check("s_latency", en_cnt, lat_s_q.pop_front());
      end
    end
    if (reset) begin
      acc_w = 0; acc_s = 0; fl_w = 1'b0; fl_s = 1'b0;
      exp_w_q.delete(); exp_s_q.delete(); lat_w_q.delete(); lat_s_q.delete();
    end else if (ce) begin
      en_cnt++;
      if (in_valid) begin
        p = longint'(din0) * longint'(din1);
        model_add(p, DW, 1'b0, in_first, acc_w, fl_w);
        model_add(p, DW, 1'b1, in_first, acc_s, fl_s);
        if (in_last) begin
          exp_w_q.push_back({fl_w, 32'(acc_w)});
          exp_s_q.push_back({fl_s, 32'(acc_s)});
          lat_w_q.push_back(en_cnt + NS_W);
          lat_s_q.push_back(en_cnt + NS_S);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input bit f, input bit l, input int a, input int b);
    in_valid = 1'b1; in_first = f; in_last = l;
    din0 = 16'(a); din1 = 8'(b);
    tick();
  endtask

  task automatic bubble(input int n);
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    repeat (n) tick();
  endtask

  // ce low with random input garbage, which must be ignored.
  task automatic stall(input int n);
    ce = 1'b0;
    in_valid = 1'($urandom_range(0, 1)); in_first = 1'($urandom_range(0, 1));
    in_last = 1'($urandom_range(0, 1));
    din0 = 16'($urandom); din1 = 8'($urandom);
    repeat (n) tick();
    ce = 1'b1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ov_w"}, ov_w, 0);
    check({tag, "_dout_w"}, 64'(dout_w), 0);
    check({tag, "_ovf_w"}, ovf_w, 0);
    check({tag, "_ov_s"}, ov_s, 0);
    check({tag, "_dout_s"}, 64'(dout_s), 0);
    check({tag, "_ovf_s"}, ovf_s, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int len, sgn, a, b;
    reset = 1'b1; ce = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    check_outputs_zero("reset");

    // Basic window: expected -800.
    beat(1, 0, 100, 2); beat(0, 0, 200, 3); beat(0, 0, -300, 4); beat(0, 1, 400, -1);
    bubble(6);

    // Single-beat window followed directly by a two-beat window.
    beat(1, 1, -32768, -128); beat(1, 0, 5, 5); beat(0, 1, 6, 6);
    bubble(6);

    // Same window with bubbles and a mid-pipeline stall; then stall while out_valid is up.
    beat(1, 0, 100, 2); bubble(1); beat(0, 0, 200, 3); stall(3);
    beat(0, 0, -300, 4); bubble(1); beat(0, 1, 400, -1);
    bubble(3); stall(2); bubble(5);

    // Overflow: wrap and clamp, then a clean window clears the flag.
    beat(1, 0, 32767, 127); beat(0, 0, 32767, 127); beat(0, 1, 32767, 127);
    beat(1, 1, 1, 1);
    bubble(6);

    // Reset (with ce low, reset still wins) aborts a partial window.
    beat(1, 0, 10, 10); beat(0, 0, 20, 20);
    reset = 1'b1; ce = 1'b0; in_valid = 1'b0;
    tick();
    reset = 1'b0; ce = 1'b1;
    check_outputs_zero("abort");
    bubble(4);
    check("abort_no_out_w", ov_w, 0);
    check("abort_no_out_s", ov_s, 0);
    beat(1, 1, 3, -7);
    bubble(6);

    // Random windows, back to back, with bubbles and stalls.
    for (int w = 0; w < 150; w++) begin
      len = $urandom_range(1, 6);
      sgn = $urandom_range(0, 1);
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 7) == 0) bubble(1);
        if ($urandom_range(0, 9) == 0) stall($urandom_range(1, 3));
        if (w % 2 == 0) begin
          a = sgn ? 32767 - int'($urandom_range(0, 255)) : -32768 + int'($urandom_range(0, 255));
          b = 127 - int'($urandom_range(0, 15));
        end else begin
          a = int'($urandom_range(0, 65535));
          b = int'($urandom_range(0, 255));
        end
        beat(j == 0, j == len - 1, a, b);
      end
    end
    bubble(12);

    check("w_drain", exp_w_q.size(), 0);
    check("s_drain", exp_s_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
